vend_arbiter: RTL and testbench
===============================

Name: vend_arbiter

Overview:
- Shares one mini_vending unit among N_REQ customer stations.
- Arbitrates pending purchase requests round-robin and sequences the vending unit's two-step protocol: money cycle with en=1, then beverage cycle with en=0.
- Waits for finish, captures change and returns the result to the granted station.
- Rejects invalid purchases locally without touching the vending unit; refunds on vending-unit timeout.

Parameters:
- N_REQ, 4, number of requesting stations (2..8).
- TIMEOUT, 8, max cycles spent in WAIT for vm_finish before abort (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  purchase request per station; level, held until done.
- money_in  input  6*N_REQ  station i money at bits [6i+5:6i].
- bev_in  input  6*N_REQ  station i beverage price at bits [6i+5:6i].
- gnt  output  N_REQ  one-hot grant, held for the whole transaction.
- done  output  N_REQ  one-cycle completion pulse to the granted station.
- change_out  output  6  change for the completing station; valid when any done bit is high.
- reject  output  1  high with done when the purchase was refused locally.
- timeout_err  output  1  high with done when vm_finish never arrived.
- busy  output  1  high in every state except IDLE.
- vm_en  output  1  to vending unit en.
- vm_money  output  6  to vending unit money.
- vm_beverage  output  6  to vending unit beverage.
- vm_change  input  6  from vending unit change.
- vm_finish  input  1  from vending unit finish.

Behaviour:
- Reset (async, immediate): FSM=IDLE, rr_ptr=0. All outputs 0, including vm_en, vm_money and vm_beverage. Latched money/bev cleared, timeout counter cleared. A reset mid-transaction drops the grant with no done pulse.
- All outputs registered except busy, which decodes state.
- States: IDLE, CHECK, LOAD, SELECT, WAIT, DONE.
- IDLE:
  - If req!=0, pick the first set bit searching from rr_ptr upward, with wrap.
  - Set gnt one-hot to the winner; latch its money_in to m_q and bev_in to b_q; go to CHECK.
  - req is sampled only in IDLE.
- CHECK (1 cycle):
  - If b_q==0 or b_q>m_q: go to DONE with reject=1 and change=m_q (full refund).
  - Otherwise go to LOAD.
- LOAD (1 cycle): vm_en=1, vm_money=m_q, vm_beverage=0.
- SELECT (1 cycle): vm_en=0, vm_money=0, vm_beverage=b_q.
- WAIT:
  - vm_en=0, vm_money=0, vm_beverage=0; count cycles from 1.
  - If vm_finish=1: latch vm_change and go to DONE.
  - Else if count==TIMEOUT: go to DONE with timeout_err=1 and change=m_q (refund).
- DONE (1 cycle):
  - done[winner]=1, with change_out, reject and timeout_err valid.
  - rr_ptr=(winner+1) mod N_REQ; next state IDLE.
  - gnt clears, done/reject/timeout_err drop, and change_out returns to 0 on the following edge.
- Latency, req rise to done:
  - Normal purchase: 5 cycles when finish arrives in the first WAIT cycle.
  - Reject: 2 cycles.
  - Timeout: 4+TIMEOUT cycles.
- Boundaries:
  - Back-to-back transactions: minimum one IDLE cycle between them.
  - A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
  - m_q==b_q is valid; expected change 0.
  - vm_finish outside WAIT is ignored.
  - The bench must not assert req with money or bev changing while granted. The values used are the ones latched in IDLE.

Optional Feature:
- VEND_STATS_EN: adds outputs stat_sales (16-bit) and stat_revenue (16-bit).
  - Both increment at DONE for successful vends only, not reject or timeout.
  - stat_sales += 1; stat_revenue += b_q zero-extended.
  - Both saturate at 16'hFFFF and reset to 0.
- Without the macro, neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset then station0 requests money=40, bev=40; model returns finish, change=0 -> done[0] 5 cycles after req, change_out=0, vm_en high exactly 1 cycle with vm_money=40.
- Stations 0, 1, 2 request simultaneously: (50,35), (55,52), (20,15) -> grants in order 0, 1, 2; change 15, 3, 5; rr_ptr=3 afterwards; then req[3] and req[0] together -> 3 granted first.
- Station1 requests money=31, bev=58 -> reject=1, change_out=31, done[1] 2 cycles after req, vm_en never asserted; bev=0 case also rejects.
- Model never asserts finish, TIMEOUT=8, station2 money=63, bev=26 -> timeout_err=1, change_out=63, done[2] after 12 cycles.
- rst asserted during WAIT -> gnt, vm_* and busy go 0 immediately without a clock edge, no done pulse; the next request is served normally with rr_ptr=0.
- With VEND_STATS_EN: vends (54,38) and (50,13) succeed plus one reject -> stat_sales=2, stat_revenue=51.

Source files
------------

// File: rtl/vend_arbiter.sv
// Round-robin arbiter that shares one mini_vending unit among N_REQ stations.
// Optional sales/revenue counters are built when VEND_STATS_EN is defined.
module vend_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [6*N_REQ-1:0] money_in,
  input  logic [6*N_REQ-1:0] bev_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [5:0]         change_out,
  output logic               reject,
  output logic               timeout_err,
  output logic               busy,
  output logic               vm_en,
  output logic [5:0]         vm_money,
  output logic [5:0]         vm_beverage,
  input  logic [5:0]         vm_change,
  input  logic               vm_finish
`ifdef VEND_STATS_EN
  ,
  output logic [15:0]        stat_sales,
  output logic [15:0]        stat_revenue
`endif
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SELECT = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       r_state;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_win;
  logic [5:0]       r_m;
  logic [5:0]       r_b;
  logic [7:0]       r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [5:0]       r_change;
  logic             r_reject;
  logic             r_terr;
  logic             r_vm_en;
  logic [5:0]       r_vm_money;
  logic [5:0]       r_vm_bev;

  logic [IW:0]      w_sum;
  logic [IW-1:0]    w_pick;
  logic             w_found;
  logic [5:0]       w_m;
  logic [5:0]       w_b;

  // First requesting station at or after the round-robin pointer, wrapping around.
  always_comb begin
    w_sum   = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ))
        w_sum = w_sum - (IW+1)'(N_REQ);
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_m = '0;
    w_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick == IW'(k)) begin
        w_m = money_in[6*k +: 6];
        w_b = bev_in[6*k +: 6];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_win      <= '0;
      r_m        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_change   <= '0;
      r_reject   <= 1'b0;
      r_terr     <= 1'b0;
      r_vm_en    <= 1'b0;
      r_vm_money <= '0;
      r_vm_bev   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt         <= '0;
            r_gnt[w_pick] <= 1'b1;
            r_win         <= w_pick;
            r_m           <= w_m;
            r_b           <= w_b;
            r_state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Free or unaffordable drinks are refused without touching the vending unit.
          if (r_b == 6'd0 || r_b > r_m) begin
            r_done[r_win] <= 1'b1;
            r_reject      <= 1'b1;
            r_change      <= r_m;
            r_state       <= S_DONE;
          end else begin
            r_vm_en    <= 1'b1;
            r_vm_money <= r_m;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_vm_en    <= 1'b0;
          r_vm_money <= '0;
          r_vm_bev   <= r_b;
          r_state    <= S_SELECT;
        end
        S_SELECT: begin
          r_vm_bev <= '0;
          r_cnt    <= 8'd1;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (vm_finish) begin
            r_done[r_win] <= 1'b1;
            r_change      <= vm_change;
            r_state       <= S_DONE;
          end else if (r_cnt == 8'(TIMEOUT)) begin
            r_done[r_win] <= 1'b1;
            r_terr        <= 1'b1;
            r_change      <= r_m;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_gnt    <= '0;
          r_done   <= '0;
          r_change <= '0;
          r_reject <= 1'b0;
          r_terr   <= 1'b0;
          r_cnt    <= '0;
          r_rr     <= (r_win == IW'(N_REQ-1)) ? '0 : r_win + IW'(1);
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VEND_STATS_EN
  logic [15:0] r_sales;
  logic [15:0] r_rev;
  logic [16:0] w_rev_sum;

  assign w_rev_sum = {1'b0, r_rev} + 17'(r_b);

  // Only vends that reached the vending unit and finished count as sales.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sales <= '0;
      r_rev   <= '0;
    end else if (r_state == S_DONE && !r_reject && !r_terr) begin
      r_sales <= (r_sales == 16'hFFFF) ? r_sales : r_sales + 16'd1;
      r_rev   <= w_rev_sum[16] ? 16'hFFFF : w_rev_sum[15:0];
    end
  end

  assign stat_sales   = r_sales;
  assign stat_revenue = r_rev;
`endif

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign change_out  = r_change;
  assign reject      = r_reject;
  assign timeout_err = r_terr;
  assign vm_en       = r_vm_en;
  assign vm_money    = r_vm_money;
  assign vm_beverage = r_vm_bev;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vend_arbiter.sv
// Self-checking bench for vend_arbiter: directed scenarios plus randomized traffic.
// Build with +define+VEND_STATS_EN to also check the sales/revenue counters.
module tb_vend_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [6*N-1:0] money_in = '0;
  logic [6*N-1:0] bev_in = '0;
  logic [N-1:0]  gnt, done;
  logic [5:0]    change_out, vm_money, vm_beverage;
  logic          reject, timeout_err, busy, vm_en;
  logic [5:0]    vm_change = '0;
  logic          vm_finish = 1'b0;
`ifdef VEND_STATS_EN
  logic [15:0]   stat_sales, stat_revenue;
`endif

  int checks = 0;
  int errors = 0;
  int rrPtr = 0;
  int expSales = 0;
  int expRev = 0;
  int moneyArr [N];
  int bevArr [N];

  vend_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .money_in(money_in), .bev_in(bev_in),
    .gnt(gnt), .done(done), .change_out(change_out), .reject(reject),
    .timeout_err(timeout_err), .busy(busy), .vm_en(vm_en), .vm_money(vm_money),
    .vm_beverage(vm_beverage), .vm_change(vm_change), .vm_finish(vm_finish)
`ifdef VEND_STATS_EN
    , .stat_sales(stat_sales), .stat_revenue(stat_revenue)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setStation(input int i, input int m, input int b);
    moneyArr[i] = m;
    bevArr[i] = b;
    money_in[6*i +: 6] = 6'(m);
    bev_in[6*i +: 6] = 6'(b);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_change"}, 32'(change_out), 0);
    checkOutput({tag, "_flags"}, {30'd0, reject, timeout_err}, 0);
    checkOutput({tag, "_vm"}, {19'd0, vm_en, vm_money, vm_beverage}, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    vm_finish = 1'b0;
    @(posedge clk);
    #1;
    checkIdleOutputs("reset");
`ifdef VEND_STATS_EN
    checkOutput("reset_stats", {stat_sales, stat_revenue}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    rrPtr = 0;
    expSales = 0;
    expRev = 0;
  endtask

  // One transaction: the model decides winner, outcome and the cycle of done from the
  // arbitration and refund rules; the bench plays the vending unit, answering finishDelay
  // cycles into WAIT with change = money - price (never, if finishDelay > TMO).
  task automatic applyStimulus(input logic [N-1:0] newReq, input int finishDelay, input bit dropEarly);
    int w, m, b, expC, expChg, idx;
    bit rej, tmo;
    logic [N-1:0] oneHot;
    logic [N-1:0] reqNow;
    reqNow = req | newReq;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rrPtr + k) % N;
      if (w < 0 && reqNow[idx]) w = idx;
    end
    if (w < 0) begin
      errors++;
      $display("[TB] FAIL model_no_request: observed none expected a request");
      return;
    end
    m = moneyArr[w];
    b = bevArr[w];
    rej = (b == 0) || (b > m);
    tmo = !rej && (finishDelay > TMO);
    expC = rej ? 1 : (tmo ? 3 + TMO : 3 + finishDelay);
    expChg = (rej || tmo) ? m : m - b;
    oneHot = '0;
    oneHot[w] = 1'b1;
    for (int c = 0; c <= expC; c++) begin
      @(negedge clk);
      if (c == 0) req = reqNow;
      if (dropEarly && c == 2) req[w] = 1'b0;
      vm_finish = !rej && ((c == 3 + finishDelay) || (c == 2));
      vm_change = (c == 2) ? 6'h2A : 6'(expChg);
      @(posedge clk);
      #1;
      checkOutput("done", 32'(done), (c == expC) ? 32'(oneHot) : 0);
      checkOutput("gnt", 32'(gnt), 32'(oneHot));
      checkOutput("busy", 32'(busy), 1);
      checkOutput("vm_en", 32'(vm_en), (!rej && c == 1) ? 1 : 0);
      checkOutput("vm_money", 32'(vm_money), (!rej && c == 1) ? 32'(m) : 0);
      checkOutput("vm_beverage", 32'(vm_beverage), (!rej && c == 2) ? 32'(b) : 0);
      checkOutput("change_out", 32'(change_out), (c == expC) ? 32'(expChg) : 0);
      checkOutput("reject", 32'(reject), (c == expC && rej) ? 1 : 0);
      checkOutput("timeout_err", 32'(timeout_err), (c == expC && tmo) ? 1 : 0);
    end
    @(negedge clk);
    vm_finish = 1'b0;
    req[w] = 1'b0;
    rrPtr = (w + 1) % N;
    if (!rej && !tmo) begin
      expSales = (expSales < 65535) ? expSales + 1 : 65535;
      expRev = (expRev + b > 65535) ? 65535 : expRev + b;
    end
    @(posedge clk);
    #1;
    checkIdleOutputs("after_done");
`ifdef VEND_STATS_EN
    checkOutput("stat_sales", 32'(stat_sales), 32'(expSales));
    checkOutput("stat_revenue", 32'(stat_revenue), 32'(expRev));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] newReq;
    int m, b, kind;
    for (int i = 0; i < N; i++) setStation(i, 0, 0);

    resetDut();
    setStation(0, 40, 40);
    applyStimulus(4'b0001, 1, 1'b0);

    resetDut();
    setStation(0, 50, 35);
    setStation(1, 55, 52);
    setStation(2, 20, 15);
    applyStimulus(4'b0111, 1, 1'b0);
    applyStimulus(4'b0000, 1, 1'b0);
    applyStimulus(4'b0000, 3, 1'b0);
    checkOutput("rr_after_three", 32'(rrPtr), 3);
    setStation(3, 30, 10);
    setStation(0, 12, 12);
    applyStimulus(4'b1001, 2, 1'b0);
    applyStimulus(4'b0000, 1, 1'b1);

    setStation(1, 31, 58);
    applyStimulus(4'b0010, 1, 1'b0);
    setStation(1, 20, 0);
    applyStimulus(4'b0010, 1, 1'b0);

    setStation(2, 63, 26);
    applyStimulus(4'b0100, TMO + 5, 1'b0);

    // Reset arrives asynchronously while station 2 sits in WAIT.
    setStation(2, 40, 10);
    @(negedge clk);
    req = 4'b0100;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_gnt", 32'(gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("async_reset");
    @(posedge clk);
    #1;
    checkOutput("reset_no_done", 32'(done), 0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    rrPtr = 0;
    expSales = 0;
    expRev = 0;

    setStation(1, 54, 38);
    setStation(3, 50, 13);
    applyStimulus(4'b1010, 1, 1'b0);
    applyStimulus(4'b0000, 2, 1'b0);
    setStation(0, 10, 20);
    applyStimulus(4'b0001, 1, 1'b0);
`ifdef VEND_STATS_EN
    checkOutput("stats_sales_2", 32'(stat_sales), 2);
    checkOutput("stats_revenue_51", 32'(stat_revenue), 51);
`endif

    for (int it = 0; it < 40; it++) begin
      newReq = '0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          kind = $urandom_range(0, 3);
          case (kind)
            0: begin m = $urandom_range(0, 63); b = 0; end
            1: begin m = $urandom_range(0, 62); b = $urandom_range(m + 1, 63); end
            2: begin m = $urandom_range(1, 63); b = m; end
            default: begin m = $urandom_range(1, 63); b = $urandom_range(1, m); end
          endcase
          setStation(i, m, b);
          newReq[i] = 1'b1;
        end
      end
      if ((req | newReq) == '0) begin
        m = $urandom_range(1, 63);
        b = $urandom_range(1, m);
        kind = $urandom_range(0, N - 1);
        setStation(kind, m, b);
        newReq[kind] = 1'b1;
      end
      applyStimulus(newReq, $urandom_range(1, TMO + 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
